// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Purpose  : Emulates a 4x4 matrix keypad toward a row-scanning controller,
//            pressing queued key codes for HOLD_CYC cycles then releasing
//            them for GAP_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
    parameter int HOLD_CYC = 64,
    parameter int GAP_CYC  = 16
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic [3:0] key,
    input  logic       key_vld,
    output logic       key_rdy,
    input  logic [3:0] x,
    output logic [3:0] y,
    output logic       busy,
    output logic       done,
    output logic [2:0] level
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYC - 1);

    logic [3:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        head_vld;
    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  act_key;
    logic        done_q;
    logic        push;
    logic        pop;
    logic [3:0]  row_sel;

    assign push    = key_vld && key_rdy;
    // head_vld lags occupancy by one cycle so a fresh key never bypasses the queue
    assign pop     = (state == ST_IDLE) && head_vld && (count != 3'd0);
    assign key_rdy = (count != 3'd4);
    assign level   = count;
    assign busy    = (count != 3'd0) || (state != ST_IDLE);
    assign done    = done_q;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 4'd0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            head_vld <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= key;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            head_vld <= (count != 3'd0);
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 16'd0;
            act_key <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        act_key <= mem[rd_ptr];
                        cnt     <= HOLD_LOAD;
                        state   <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (cnt == 16'd0) begin
                        cnt   <= GAP_LOAD;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == 16'd0) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    // Only a single-low x matching the active row returns a column; anything else is idle
    assign row_sel = ~(4'b0001 << act_key[3:2]);

    always_comb begin
        y = 4'b1111;
        if ((state == ST_PRESS) && (x == row_sel)) begin
            y[act_key[1:0]] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Purpose  : Directed self-checking bench for keypad_emulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    logic       ck;
    logic       rst_n;
    logic [3:0] key;
    logic       key_vld;
    logic       key_rdy;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic [2:0] level;

    logic       scan_en;
    logic [3:0] man_x;
    logic [1:0] scan_row;
    logic       got;
    logic [3:0] seen [$];

    int checks_total;
    int checks_passed;

    keypad_emulator #(
        .HOLD_CYC(4),
        .GAP_CYC (2)
    ) dut (
        .ck     (ck),
        .rst_n  (rst_n),
        .key    (key),
        .key_vld(key_vld),
        .key_rdy(key_rdy),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .level  (level)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Simple row scanner: one row low per cycle, rotating
    initial scan_row = 2'd0;
    always @(posedge ck) scan_row <= scan_row + 2'd1;

    always_comb begin
        x = scan_en ? ~(4'b0001 << scan_row) : man_x;
    end

    // Scanner-side decoder: capture one key code per press
    initial got = 1'b0;
    always @(negedge ck) begin
        if (!rst_n) begin
            got <= 1'b0;
        end else begin
            if (y != 4'b1111 && !got) begin
                logic [1:0] r;
                logic [1:0] c;
                r = 2'd0;
                c = 2'd0;
                for (int i = 0; i < 4; i++) begin
                    if (!x[i]) r = 2'(i);
                    if (!y[i]) c = 2'(i);
                end
                seen.push_back({r, c});
                got <= 1'b1;
            end
            if (done) got <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        chk("idle_timeout", 16'(busy), 16'd0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        chk("done_timeout", 16'(done), 16'd1);
    endtask

    task automatic push_one(input logic [3:0] k);
        key     = k;
        key_vld = 1'b1;
        step();
        key_vld = 1'b0;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n   = 1'b0;
        key     = 4'd0;
        key_vld = 1'b0;
        scan_en = 1'b0;
        man_x   = 4'b1101;

        repeat (3) step();
        chk("rst_level", 16'(level), 16'd0);
        chk("rst_rdy",   16'(key_rdy), 16'd1);
        chk("rst_busy",  16'(busy), 16'd0);
        chk("rst_done",  16'(done), 16'd0);
        chk("rst_y",     16'(y), 16'hF);
        rst_n = 1'b1;
        step();

        // Single key 6 with fixed x = row 1
        push_one(4'h6);
        chk("k6_level", 16'(level), 16'd1);
        chk("k6_y_n0",  16'(y), 16'hF);
        step();
        chk("k6_y_n1",  16'(y), 16'hF);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("k6_press%0d", i), 16'(y), 16'b1011);
        end
        step();
        chk("k6_rel_y",   16'(y), 16'hF);
        chk("k6_rel_d0",  16'(done), 16'd0);
        step();
        chk("k6_rel_d1",  16'(done), 16'd0);
        step();
        chk("k6_done",    16'(done), 16'd1);
        step();
        chk("k6_done_off", 16'(done), 16'd0);
        chk("k6_busy",    16'(busy), 16'd0);

        // Scan masking with key F
        man_x = 4'b1110;
        push_one(4'hF);
        step();
        step();
        man_x = 4'b1110; #1; chk("kf_x1110", 16'(y), 16'hF);
        man_x = 4'b1101; #1; chk("kf_x1101", 16'(y), 16'hF);
        man_x = 4'b1011; #1; chk("kf_x1011", 16'(y), 16'hF);
        man_x = 4'b0111; #1; chk("kf_x0111", 16'(y), 16'b0111);
        man_x = 4'b1100; #1; chk("kf_x1100", 16'(y), 16'hF);
        wait_idle(50);

        // Queue full with scanner in the loop
        scan_en = 1'b1;
        seen.delete();
        push_one(4'h0);
        step();
        step();
        for (int k = 1; k <= 4; k++) begin
            key     = 4'(k);
            key_vld = 1'b1;
            step();
        end
        chk("full_level", 16'(level), 16'd4);
        chk("full_rdy",   16'(key_rdy), 16'd0);
        key = 4'h5;
        wait_done(50);
        chk("full_at_done", 16'(level), 16'd4);
        step();
        chk("full_pop",     16'(level), 16'd3);
        chk("full_rdy_up",  16'(key_rdy), 16'd1);
        step();
        key_vld = 1'b0;
        chk("full_refill",  16'(level), 16'd4);
        wait_idle(200);
        chk("full_n", 16'(seen.size()), 16'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < seen.size()) chk($sformatf("full_ord%0d", i), 16'(seen[i]), 16'(i));
        end

        // Push and pop on the same edge at level 1
        seen.delete();
        push_one(4'h7);
        step();
        step();
        push_one(4'h8);
        chk("l1_level", 16'(level), 16'd1);
        wait_done(50);
        key     = 4'h9;
        key_vld = 1'b1;
        step();
        key_vld = 1'b0;
        chk("l1_pushpop", 16'(level), 16'd1);
        wait_idle(100);
        chk("l1_n", 16'(seen.size()), 16'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size()) chk($sformatf("l1_ord%0d", i), 16'(seen[i]), 16'(7 + i));
        end

        // Asynchronous reset mid-press with two keys queued
        scan_en = 1'b0;
        man_x   = 4'b1011;
        key_vld = 1'b1;
        key = 4'hA; step();
        key = 4'hB; step();
        key = 4'hC; step();
        key_vld = 1'b0;
        chk("rmp_y_press", 16'(y), 16'b1011);
        chk("rmp_level",   16'(level), 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmp_y",     16'(y), 16'hF);
        chk("rmp_lvl0",  16'(level), 16'd0);
        chk("rmp_busy",  16'(busy), 16'd0);
        chk("rmp_rdy",   16'(key_rdy), 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rmp_nodone%0d", i), 16'(done), 16'd0);
        end
        rst_n = 1'b1;
        push_one(4'h3);
        chk("post_rst_accept", 16'(level), 16'd1);
        wait_idle(50);

        // Closed loop: keys 0..15 decoded by the scanner
        scan_en = 1'b1;
        seen.delete();
        for (int k = 0; k < 16; k++) begin
            key     = 4'(k);
            key_vld = 1'b1;
            for (int t = 0; t < 100 && !key_rdy; t++) step();
            step();
            key_vld = 1'b0;
        end
        wait_idle(500);
        chk("loop_n", 16'(seen.size()), 16'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < seen.size()) chk($sformatf("loop_k%0d", i), 16'(seen[i]), 16'(i));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
